// File: rtl/pmem_arbiter_pkg.sv
// Shared types for the physical-memory arbiter: LC-3b word/line types,
// the arbiter state encoding and the round-robin grant owner.
package pmem_arbiter_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_c_block;

  typedef enum logic [2:0] {
    ARB_IDLE = 3'd0,
    ARB_I_RD = 3'd1,
    ARB_D_RD = 3'd2,
    ARB_D_WR = 3'd3,
    ARB_GAP  = 3'd4
  } lc3b_arb_state;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } arb_grant_e;

endpackage

// File: rtl/pmem_arbiter.sv
// Arbiter sharing one physical-memory port between the L1 I-cache and the
// L1 D-cache. One line transaction is in flight at a time; the command to
// memory comes from registers so it stays stable for the whole access.
// A one-cycle GAP after every response keeps a cache that has not yet
// dropped its request from being served twice.
module pmem_arbiter
  import pmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              icache_pmem_read,
  input  logic [ADDR_W-1:0] icache_pmem_address,
  output logic              icache_pmem_resp,
  output logic [LINE_W-1:0] icache_pmem_rdata,

  input  logic              dcache_pmem_read,
  input  logic              dcache_pmem_write,
  input  logic [ADDR_W-1:0] dcache_pmem_address,
  input  logic [LINE_W-1:0] dcache_pmem_wdata,
  output logic              dcache_pmem_resp,
  output logic [LINE_W-1:0] dcache_pmem_rdata,

  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,

  output logic              busy
);

  lc3b_arb_state     state_q, state_d;
  arb_grant_e        last_grant_q, last_grant_d;
  logic              lock_q, lock_d;
  logic              pmem_read_q, pmem_read_d;
  logic              pmem_write_q, pmem_write_d;
  logic [ADDR_W-1:0] pmem_address_q, pmem_address_d;
  logic [LINE_W-1:0] pmem_wdata_q, pmem_wdata_d;

  logic              d_req;
  logic              i_req;
  logic              pick_dcache;

  assign d_req = dcache_pmem_read | dcache_pmem_write;
  assign i_req = icache_pmem_read;

  // D wins when alone, when I was served last, or when a just-finished
  // write-back still owes its paired fill (the lock).
  assign pick_dcache = d_req &&
                       (!i_req ||
                        (last_grant_q == GRANT_I) ||
                        (lock_q && dcache_pmem_read));

  // Next-state and command-register update for the arbiter FSM.
  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    lock_d         = lock_q;
    pmem_read_d    = pmem_read_q;
    pmem_write_d   = pmem_write_q;
    pmem_address_d = pmem_address_q;
    pmem_wdata_d   = pmem_wdata_q;

    case (state_q)
      ARB_IDLE: begin
        if (pick_dcache) begin
          // Write-back is always issued before a fill from the same cache.
          state_d        = dcache_pmem_write ? ARB_D_WR : ARB_D_RD;
          pmem_read_d    = !dcache_pmem_write;
          pmem_write_d   = dcache_pmem_write;
          pmem_address_d = dcache_pmem_address;
          pmem_wdata_d   = dcache_pmem_wdata;
          last_grant_d   = GRANT_D;
          lock_d         = 1'b0;
        end else if (i_req) begin
          state_d        = ARB_I_RD;
          pmem_read_d    = 1'b1;
          pmem_write_d   = 1'b0;
          pmem_address_d = icache_pmem_address;
          pmem_wdata_d   = '0;
          last_grant_d   = GRANT_I;
          lock_d         = 1'b0;
        end
      end

      ARB_I_RD, ARB_D_RD, ARB_D_WR: begin
        if (pmem_resp) begin
          state_d      = ARB_GAP;
          pmem_read_d  = 1'b0;
          pmem_write_d = 1'b0;
          // An eviction is normally followed by its fill; keep that pair together.
          if (state_q == ARB_D_WR) begin
            lock_d = 1'b1;
          end
        end
      end

      ARB_GAP: begin
        state_d = ARB_IDLE;
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State and command registers; reset abandons any in-flight access.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ARB_IDLE;
      last_grant_q   <= GRANT_I;
      lock_q         <= 1'b0;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      lock_q         <= lock_d;
      pmem_read_q    <= pmem_read_d;
      pmem_write_q   <= pmem_write_d;
      pmem_address_q <= pmem_address_d;
      pmem_wdata_q   <= pmem_wdata_d;
    end
  end

  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;
  assign busy         = (state_q != ARB_IDLE);

  // Completion goes only to the owner of the current access; a stray
  // strobe in IDLE or GAP reaches neither cache.
  assign icache_pmem_resp  = pmem_resp && (state_q == ARB_I_RD);
  assign dcache_pmem_resp  = pmem_resp && ((state_q == ARB_D_RD) || (state_q == ARB_D_WR));
  assign icache_pmem_rdata = pmem_rdata;
  assign dcache_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: reset, single fill, round-robin under
// contention, evict+fill lock, stale-request guard and reset mid-access.
module tb_pmem_arbiter;

  logic         clk;
  logic         rst_n;
  logic         icache_pmem_read;
  logic [15:0]  icache_pmem_address;
  logic         icache_pmem_resp;
  logic [127:0] icache_pmem_rdata;
  logic         dcache_pmem_read;
  logic         dcache_pmem_write;
  logic [15:0]  dcache_pmem_address;
  logic [127:0] dcache_pmem_wdata;
  logic         dcache_pmem_resp;
  logic [127:0] dcache_pmem_rdata;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  logic         busy;

  int errors;
  int checks;

  pmem_arbiter #(.ADDR_W(16), .LINE_W(128)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .icache_pmem_read    (icache_pmem_read),
    .icache_pmem_address (icache_pmem_address),
    .icache_pmem_resp    (icache_pmem_resp),
    .icache_pmem_rdata   (icache_pmem_rdata),
    .dcache_pmem_read    (dcache_pmem_read),
    .dcache_pmem_write   (dcache_pmem_write),
    .dcache_pmem_address (dcache_pmem_address),
    .dcache_pmem_wdata   (dcache_pmem_wdata),
    .dcache_pmem_resp    (dcache_pmem_resp),
    .dcache_pmem_rdata   (dcache_pmem_rdata),
    .pmem_read           (pmem_read),
    .pmem_write          (pmem_write),
    .pmem_address        (pmem_address),
    .pmem_wdata          (pmem_wdata),
    .pmem_rdata          (pmem_rdata),
    .pmem_resp           (pmem_resp),
    .busy                (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    icache_pmem_read = 1'b1;
    icache_pmem_address = 16'h0BAD;
    tick();
    tick();
    checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL rst_pmem_read: got %b want 0", pmem_read); end
    checks++; if (pmem_write !== 1'b0) begin errors++; $display("FAIL rst_pmem_write: got %b want 0", pmem_write); end
    checks++; if (pmem_address !== 16'h0000) begin errors++; $display("FAIL rst_pmem_address: got %h want 0000", pmem_address); end
    checks++; if (pmem_wdata !== 128'h0) begin errors++; $display("FAIL rst_pmem_wdata: got %h want 0", pmem_wdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if ({icache_pmem_resp, dcache_pmem_resp} !== 2'b00) begin errors++; $display("FAIL rst_resp: got %b want 00", {icache_pmem_resp, dcache_pmem_resp}); end
    icache_pmem_read = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_ifill();
    logic [127:0] line;
    line = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    icache_pmem_read = 1'b1;
    icache_pmem_address = 16'h1230;
    tick();
    checks++; if ({pmem_read, pmem_write} !== 2'b10) begin errors++; $display("FAIL ifill_cmd: got rd/wr %b want 10", {pmem_read, pmem_write}); end
    checks++; if (pmem_address !== 16'h1230) begin errors++; $display("FAIL ifill_addr: got %h want 1230", pmem_address); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ifill_busy: got %b want 1", busy); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({pmem_read, pmem_address, icache_pmem_resp} !== {1'b1, 16'h1230, 1'b0}) begin
        errors++; $display("FAIL ifill_hold: got rd=%b addr=%h iresp=%b want rd=1 addr=1230 iresp=0", pmem_read, pmem_address, icache_pmem_resp);
      end
    end
    pmem_rdata = line;
    pmem_resp = 1'b1;
    #1;
    checks++; if (icache_pmem_resp !== 1'b1) begin errors++; $display("FAIL ifill_iresp: got %b want 1", icache_pmem_resp); end
    checks++; if (icache_pmem_rdata !== line) begin errors++; $display("FAIL ifill_rdata: got %h want %h", icache_pmem_rdata, line); end
    checks++; if (dcache_pmem_resp !== 1'b0) begin errors++; $display("FAIL ifill_dresp: got %b want 0", dcache_pmem_resp); end
    tick();
    pmem_resp = 1'b0;
    icache_pmem_read = 1'b0;
    #1;
    checks++; if ({pmem_read, busy, icache_pmem_resp} !== 3'b010) begin errors++; $display("FAIL ifill_gap: got rd/busy/iresp %b want 010", {pmem_read, busy, icache_pmem_resp}); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ifill_idle: got busy %b want 0", busy); end
  endtask

  task automatic test_stale_request();
    icache_pmem_read = 1'b1;
    icache_pmem_address = 16'h7770;
    tick();
    checks++; if (pmem_read !== 1'b1) begin errors++; $display("FAIL stale_first_cmd: got %b want 1", pmem_read); end
    tick();
    pmem_rdata = {4{32'hFACE_0001}};
    pmem_resp = 1'b1;
    #1;
    checks++; if (icache_pmem_resp !== 1'b1) begin errors++; $display("FAIL stale_iresp: got %b want 1", icache_pmem_resp); end
    tick();
    pmem_resp = 1'b0;
    tick();
    icache_pmem_read = 1'b0;
    checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL stale_regrant: got pmem_read %b want 0", pmem_read); end
    tick();
    checks++; if ({pmem_read, busy} !== 2'b00) begin errors++; $display("FAIL stale_idle: got rd/busy %b want 00", {pmem_read, busy}); end
  endtask

  task automatic test_contention();
    logic         exp_d;
    logic [15:0]  exp_addr;
    logic [127:0] line;
    apply_reset();
    icache_pmem_read = 1'b1;
    icache_pmem_address = 16'h1000;
    dcache_pmem_read = 1'b1;
    dcache_pmem_address = 16'h2000;
    for (int k = 0; k < 4; k++) begin
      exp_d = ((k % 2) == 0);
      exp_addr = exp_d ? 16'h2000 : 16'h1000;
      line = {4{32'hC0DE_0000 + 32'(k)}};
      tick();
      checks++;
      if ({pmem_read, pmem_write, pmem_address} !== {2'b10, exp_addr}) begin
        errors++; $display("FAIL rr_grant%0d: got rd/wr %b addr %h want 10 addr %h", k, {pmem_read, pmem_write}, pmem_address, exp_addr);
      end
      tick();
      pmem_rdata = line;
      pmem_resp = 1'b1;
      #1;
      checks++;
      if ({dcache_pmem_resp, icache_pmem_resp} !== {exp_d, !exp_d}) begin
        errors++; $display("FAIL rr_resp%0d: got d/i resp %b want %b", k, {dcache_pmem_resp, icache_pmem_resp}, {exp_d, !exp_d});
      end
      checks++;
      if ((exp_d ? dcache_pmem_rdata : icache_pmem_rdata) !== line) begin
        errors++; $display("FAIL rr_rdata%0d: got %h want %h", k, (exp_d ? dcache_pmem_rdata : icache_pmem_rdata), line);
      end
      tick();
      pmem_resp = 1'b0;
      checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL rr_gap%0d: got pmem_read %b want 0", k, pmem_read); end
      tick();
      checks++; if ({pmem_read, busy} !== 2'b00) begin errors++; $display("FAIL rr_idle%0d: got rd/busy %b want 00", k, {pmem_read, busy}); end
    end
    icache_pmem_read = 1'b0;
    dcache_pmem_read = 1'b0;
    tick();
  endtask

  task automatic test_evict_fill();
    logic [127:0] wb;
    logic [127:0] fill;
    wb = {16{8'hA5}};
    fill = {8{16'hBEEF}};
    apply_reset();
    dcache_pmem_write = 1'b1;
    dcache_pmem_read = 1'b1;
    dcache_pmem_address = 16'h4000;
    dcache_pmem_wdata = wb;
    icache_pmem_read = 1'b1;
    icache_pmem_address = 16'h1230;
    tick();
    checks++; if ({pmem_read, pmem_write} !== 2'b01) begin errors++; $display("FAIL evict_cmd: got rd/wr %b want 01", {pmem_read, pmem_write}); end
    checks++; if (pmem_address !== 16'h4000) begin errors++; $display("FAIL evict_addr: got %h want 4000", pmem_address); end
    checks++; if (pmem_wdata !== wb) begin errors++; $display("FAIL evict_wdata: got %h want %h", pmem_wdata, wb); end
    tick();
    pmem_resp = 1'b1;
    #1;
    checks++; if ({dcache_pmem_resp, icache_pmem_resp} !== 2'b10) begin errors++; $display("FAIL evict_resp: got d/i %b want 10", {dcache_pmem_resp, icache_pmem_resp}); end
    tick();
    pmem_resp = 1'b0;
    dcache_pmem_write = 1'b0;
    checks++; if (pmem_write !== 1'b0) begin errors++; $display("FAIL evict_gap: got pmem_write %b want 0", pmem_write); end
    tick();
    tick();
    checks++;
    if ({pmem_read, pmem_write, pmem_address} !== {2'b10, 16'h4000}) begin
      errors++; $display("FAIL lock_grant_d: got rd/wr %b addr %h want 10 addr 4000", {pmem_read, pmem_write}, pmem_address);
    end
    tick();
    pmem_rdata = fill;
    pmem_resp = 1'b1;
    #1;
    checks++; if ({dcache_pmem_resp, icache_pmem_resp} !== 2'b10) begin errors++; $display("FAIL lock_resp: got d/i %b want 10", {dcache_pmem_resp, icache_pmem_resp}); end
    checks++; if (dcache_pmem_rdata !== fill) begin errors++; $display("FAIL lock_rdata: got %h want %h", dcache_pmem_rdata, fill); end
    tick();
    pmem_resp = 1'b0;
    dcache_pmem_read = 1'b0;
    tick();
    tick();
    checks++;
    if ({pmem_read, pmem_write, pmem_address} !== {2'b10, 16'h1230}) begin
      errors++; $display("FAIL after_lock_i: got rd/wr %b addr %h want 10 addr 1230", {pmem_read, pmem_write}, pmem_address);
    end
    pmem_resp = 1'b1;
    #1;
    checks++; if ({dcache_pmem_resp, icache_pmem_resp} !== 2'b01) begin errors++; $display("FAIL after_lock_resp: got d/i %b want 01", {dcache_pmem_resp, icache_pmem_resp}); end
    tick();
    pmem_resp = 1'b0;
    icache_pmem_read = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_write();
    dcache_pmem_write = 1'b1;
    dcache_pmem_address = 16'h4440;
    dcache_pmem_wdata = {8{16'h5A5A}};
    tick();
    checks++; if (pmem_write !== 1'b1) begin errors++; $display("FAIL midrst_cmd: got pmem_write %b want 1", pmem_write); end
    tick();
    rst_n = 1'b0;
    tick();
    checks++; if ({pmem_write, pmem_read, busy} !== 3'b000) begin errors++; $display("FAIL midrst_abort: got wr/rd/busy %b want 000", {pmem_write, pmem_read, busy}); end
    rst_n = 1'b1;
    dcache_pmem_write = 1'b0;
    pmem_resp = 1'b1;
    #1;
    checks++; if ({dcache_pmem_resp, icache_pmem_resp} !== 2'b00) begin errors++; $display("FAIL midrst_late_resp: got d/i %b want 00", {dcache_pmem_resp, icache_pmem_resp}); end
    tick();
    pmem_resp = 1'b0;
    checks++; if ({pmem_write, pmem_read, busy} !== 3'b000) begin errors++; $display("FAIL midrst_after: got wr/rd/busy %b want 000", {pmem_write, pmem_read, busy}); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    icache_pmem_read = 1'b0;
    icache_pmem_address = '0;
    dcache_pmem_read = 1'b0;
    dcache_pmem_write = 1'b0;
    dcache_pmem_address = '0;
    dcache_pmem_wdata = '0;
    pmem_rdata = '0;
    pmem_resp = 1'b0;

    test_reset();
    test_single_ifill();
    test_stale_request();
    test_contention();
    test_evict_fill();
    test_reset_mid_write();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
